// File: rtl/alu_pkg.sv
// Shared constants, state encoding and nibble helpers for the 16-bit ALU chain controller.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int NIB_W  = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_XOR;
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic [NIB_W-1:0] nibble(input logic [DATA_W-1:0] v, input logic [1:0] i);
        return v[i*NIB_W +: NIB_W];
    endfunction

endpackage

// File: rtl/alu16_chain_fsm.sv
// Control FSM for the nibble-serial ALU chain: state, nibble index and both handshakes.
// An illegal op is held pending in IDLE for one cycle so its result appears one edge after acceptance.
module alu16_chain_fsm
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       cmd_illegal,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic       accept,
    output logic       run,
    output logic [1:0] idx
);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       err_pend_q, err_pend_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            err_pend_q <= err_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_pend_d = err_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (err_pend_q) begin
                    state_d    = ST_DONE;
                    err_pend_d = 1'b0;
                end else if (in_valid) begin
                    if (cmd_illegal) begin
                        err_pend_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        idx_d   = 2'd0;
                    end
                end
            end
            ST_RUN: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !err_pend_q;
        accept    = in_ready && in_valid;
        run       = (state_q == ST_RUN);
        out_valid = (state_q == ST_DONE);
        idx       = idx_q;
    end

endmodule

// File: rtl/alu16_chain_ctrl.sv
// 16-bit ALU built by chaining four passes through an external 4-bit combinational ALU.
// Define ALU16_CHAIN_FLAGS_EN to generate the zero/carry/overflow flag registers; otherwise they read 0.
module alu16_chain_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [2:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_zero,
    output logic        out_carry,
    output logic        out_overflow,
    output logic        out_err,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_c,
    output logic        alu_cin,
    input  logic [3:0]  alu_result,
    input  logic        alu_carry,
    input  logic        alu_overflow
);

    logic              accept;
    logic              run;
    logic [1:0]        idx;

    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2:0]        op_q, op_d;
    logic              carry_q, carry_d, err_q, err_d;

    alu16_chain_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .cmd_illegal(!op_is_legal(in_op)),
        .out_ready  (out_ready),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .accept     (accept),
        .run        (run),
        .idx        (idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
        end
    end

    // Clearing the result on acceptance gives illegal ops their all-zero result for free.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        carry_d  = carry_q;
        err_d    = err_q;
        if (accept) begin
            a_d      = in_a;
            b_d      = in_b;
            op_d     = in_op;
            result_d = '0;
            carry_d  = 1'b0;
            err_d    = !op_is_legal(in_op);
        end else if (run) begin
            case (idx)
                2'd0:    result_d[3:0]   = alu_result;
                2'd1:    result_d[7:4]   = alu_result;
                2'd2:    result_d[11:8]  = alu_result;
                default: result_d[15:12] = alu_result;
            endcase
            carry_d = op_is_arith(op_q) && alu_carry;
        end
    end

    // Subtraction is a + ~b + 1: invert b here and inject the +1 as the nibble-0 carry-in.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_c   = '0;
        alu_cin = 1'b0;
        if (run) begin
            alu_a   = nibble(a_q, idx);
            alu_b   = (op_q == OP_SUB) ? nibble(~b_q, idx) : nibble(b_q, idx);
            alu_c   = op_is_arith(op_q) ? OP_ADD : op_q;
            alu_cin = (idx == 2'd0) ? (op_q == OP_SUB) : (op_is_arith(op_q) && carry_q);
        end
    end

    assign out_result = result_q;
    assign out_err    = err_q;

`ifdef ALU16_CHAIN_FLAGS_EN
    logic zero_q, zero_d, cflag_q, cflag_d, oflag_q, oflag_d;
    logic last_nib;

    assign last_nib = run && (idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q  <= 1'b0;
            cflag_q <= 1'b0;
            oflag_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            cflag_q <= cflag_d;
            oflag_q <= oflag_d;
        end
    end

    always_comb begin
        zero_d  = zero_q;
        cflag_d = cflag_q;
        oflag_d = oflag_q;
        if (accept) begin
            zero_d  = 1'b0;
            cflag_d = 1'b0;
            oflag_d = 1'b0;
        end else if (last_nib) begin
            zero_d  = (alu_result == 4'h0) && (result_q[11:0] == 12'h000);
            cflag_d = op_is_arith(op_q) && alu_carry;
            oflag_d = op_is_arith(op_q) && alu_overflow;
        end
    end

    assign out_zero     = zero_q;
    assign out_carry    = cflag_q;
    assign out_overflow = oflag_q;
`else
    logic unused_alu_ovf;

    assign unused_alu_ovf = alu_overflow;
    assign out_zero       = 1'b0;
    assign out_carry      = 1'b0;
    assign out_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_alu16_chain_ctrl.sv
// Scoreboard testbench for alu16_chain_ctrl with a behavioural 4-bit ALU and a 16-bit reference model.
module tb_alu16_chain_ctrl;

`ifdef ALU16_CHAIN_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct {
        logic [15:0] r;
        logic        z;
        logic        c;
        logic        v;
        logic        e;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic        out_zero, out_carry, out_overflow, out_err;
    logic [3:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_c;
    logic        alu_cin, alu_carry, alu_overflow;
    logic [4:0]  alu_sum;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   hold_left = 0;
    bit   seen = 1'b0;
    bit   expect_idle = 1'b0;

    alu16_chain_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_carry   (out_carry),
        .out_overflow(out_overflow),
        .out_err     (out_err),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_c       (alu_c),
        .alu_cin     (alu_cin),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .alu_overflow(alu_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External 4-bit ALU: c=000 adds with carry-in, 010..101 are bitwise ops without flags.
    always_comb begin
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        alu_result   = 4'h0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_c)
            3'b000: begin
                alu_result   = alu_sum[3:0];
                alu_carry    = alu_sum[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (alu_sum[3] != alu_a[3]);
            end
            3'b010:  alu_result = ~alu_a;
            3'b011:  alu_result = alu_a & alu_b;
            3'b100:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = alu_a ^ alu_b;
            default: alu_result = 4'h0;
        endcase
    end

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input int t);
        exp_t        e;
        logic [16:0] s;
        e.r = '0; e.z = 1'b0; e.c = 1'b0; e.v = 1'b0; e.e = 1'b0;
        case (op)
            3'd0: begin
                s   = {1'b0, a} + {1'b0, b};
                e.r = s[15:0];
                e.c = s[16];
                e.v = (a[15] == b[15]) && (e.r[15] != a[15]);
            end
            3'd1: begin
                e.r = a - b;
                e.c = (a >= b);
                e.v = (a[15] != b[15]) && (e.r[15] != a[15]);
            end
            3'd2:    e.r = ~a;
            3'd3:    e.r = a & b;
            3'd4:    e.r = a | b;
            3'd5:    e.r = a ^ b;
            default: e.e = 1'b1;
        endcase
        e.z = !e.e && (e.r == 16'h0000);
        if (!FLAGS) begin
            e.z = 1'b0; e.c = 1'b0; e.v = 1'b0;
        end
        e.due = t + ((op <= 3'd5) ? 4 : 1);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic checkOutput(input exp_t e);
        chk("result", {16'h0, out_result}, {16'h0, e.r});
        chk("zero", {31'h0, out_zero}, {31'h0, e.z});
        chk("carry", {31'h0, out_carry}, {31'h0, e.c});
        chk("overflow", {31'h0, out_overflow}, {31'h0, e.v});
        chk("err", {31'h0, out_err}, {31'h0, e.e});
        chk("in_ready_in_done", {31'h0, in_ready}, 32'h0);
        chk("alu_quiet_in_done", {20'h0, alu_a, alu_b, alu_c, alu_cin}, 32'h0);
    endtask

    // Monitor: checks the head of the scoreboard while out_valid is up, pops on handshake.
    always @(negedge clk) begin
        if (rst) begin
            seen        = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                chk("idle_after_handshake", {31'h0, in_ready}, 32'h1);
                expect_idle = 1'b0;
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 32'h1, 32'h0);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc, q[0].due);
                        seen = 1'b1;
                    end
                    checkOutput(q[0]);
                end
            end
            if (out_valid && hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                seen        = 1'b0;
                expect_idle = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'h0, 32'h1);
            return;
        end
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(model(a, b, op, cyc));
        if (op > 3'd5) chk("illegal_alu_quiet", {20'h0, alu_a, alu_b, alu_c, alu_cin}, 32'h0);
        else           chk("first_nibble_a", {28'h0, alu_a}, {28'h0, a[3:0]});
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_op    = 3'($urandom);
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (q.size() != 0 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_result", {16'h0, out_result}, 32'h0);
        chk("reset_flags", {28'h0, out_zero, out_carry, out_overflow, out_err}, 32'h0);
        chk("reset_alu", {20'h0, alu_a, alu_b, alu_c, alu_cin}, 32'h0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);

        $display("[TB] directed corner cases");
        applyStimulus(16'h00FF, 16'h0001, 3'b000);
        applyStimulus(16'h8000, 16'h0001, 3'b001);
        applyStimulus(16'h0000, 16'h0001, 3'b001);
        applyStimulus(16'hFFFF, 16'h0001, 3'b000);
        applyStimulus(16'hA5A5, 16'hA5A5, 3'b101);
        applyStimulus(16'h1234, 16'h5678, 3'b110);
        applyStimulus(16'hFFFF, 16'h0000, 3'b111);
        waitDrain();

        $display("[TB] back-pressure hold");
        hold_left = 3;
        applyStimulus(16'h1234, 16'h1111, 3'b000);
        waitDrain();

        $display("[TB] reset mid-run");
        applyStimulus(16'h1357, 16'h2468, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_run_nibble2", {28'h0, alu_a}, 32'h3);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_result", {16'h0, out_result}, 32'h0);
        chk("rst_flags", {28'h0, out_zero, out_carry, out_overflow, out_err}, 32'h0);
        chk("rst_alu", {20'h0, alu_a, alu_b, alu_c, alu_cin}, 32'h0);
        void'(q.pop_back());
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        applyStimulus(16'h00FF, 16'h0001, 3'b000);
        waitDrain();

        $display("[TB] random commands");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        waitDrain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu16_chain_ctrl.md
ALU16_CHAIN_CTRL -- requirements
Module: alu16_chain_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: in_valid/in_ready  in/out  1/1  command handshake; in_a, in_b  in  16  operands; in_op  in  3  operation code.
REQ-004 SHALL have ports: out_valid/out_ready  out/in  1/1  result handshake; out_result  out  16; out_zero, out_carry, out_overflow, out_err  out  1 each.
REQ-005 SHALL have ports to the external combinational 4-bit ALU: alu_a, alu_b  out  4; alu_c  out  3; alu_cin  out  1; alu_result  in  4; alu_carry, alu_overflow  in  1.

Function
REQ-006 SHALL implement states IDLE, RUN, DONE; 2-bit nibble index idx counts 0..3 in RUN.
REQ-007 SHALL assert in_ready only in IDLE; command accepted when in_valid && in_ready at an edge; operands and op latched; transition to RUN, idx=0.
REQ-008 SHALL, in RUN, drive alu_a = a[4*idx+3:4*idx], alu_b = (op==001 ? ~b : b) nibble, capture alu_result into result nibble idx at each edge, increment idx; after idx=3 capture go to DONE.
REQ-009 SHALL encode ops: 000 add, 001 sub, 010 NOT a, 011 AND, 100 OR, 101 XOR; alu_c = 000 for both add and sub (sub done as a + ~b + 1), else alu_c = in_op.
REQ-010 SHALL drive alu_cin: nibble 0 = 1 for sub, 0 otherwise; nibbles 1..3 = registered alu_carry of previous nibble for add/sub, 0 for logic ops.
REQ-011 SHALL set out_carry = alu_carry of nibble 3 and out_overflow = alu_overflow of nibble 3 for add/sub; both 0 for logic ops (sub: carry 1 = no borrow).
REQ-012 SHALL set out_zero = (16-bit result == 0) for every legal op.
REQ-013 SHALL treat op 110 and 111 as illegal: no RUN, go IDLE->DONE on the next edge with out_result=0, out_err=1, other flags 0.
REQ-014 SHALL assert out_valid only in DONE; outputs stable while out_valid && !out_ready; on out_valid && out_ready edge return to IDLE.
REQ-015 SHALL have latency: legal command accepted at edge T -> out_valid high after edge T+4; illegal -> after edge T+1; throughput one command per 5 (legal) cycles minimum.
REQ-016 SHALL ignore in_valid outside IDLE; in_a/in_b/in_op changes after acceptance SHALL not affect the result.
REQ-017 SHALL drive alu_a, alu_b, alu_c, alu_cin = 0 outside RUN.

Reset
REQ-018 SHALL, on rst high (any time, incl. mid-RUN or DONE), immediately force IDLE, idx=0, out_valid=0, out_result=0, all flags 0, carry register 0; in_ready=1 once rst deasserts.
REQ-019 SHALL discard any in-flight command on reset; no out_valid for it.

Configuration
REQ-020 SHALL honour macro ALU16_CHAIN_FLAGS_EN: defined -> out_zero/out_carry/out_overflow per REQ-011/012; undefined -> these three tied 0 and flag registers not generated; out_err and out_result unaffected.

Structure
REQ-021 SHALL place op-code constants (OP_ADD..OP_XOR), state encoding and width constant 16/4 in shared package alu_pkg.
REQ-022 SHALL keep a single sub-module alu16_chain_fsm (state, idx, handshake); datapath nibble mux/capture in top.

Verification
REQ-023 add 0x00FF + 0x0001 -> out_result 0x0100, carry 0, overflow 0, zero 0, out_valid 4 cycles after accept.
REQ-024 sub 0x8000 - 0x0001 -> out_result 0x7FFF, overflow 1, carry 1; sub 0x0000 - 0x0001 -> 0xFFFF, carry 0.
REQ-025 add 0xFFFF + 0x0001 -> 0x0000, zero 1, carry 1; XOR 0xA5A5^0xA5A5 -> 0x0000, zero 1, carry 0.
REQ-026 op 110 with any operands -> out_err 1, out_result 0 one cycle after accept, no ALU activity (alu_* all 0).
REQ-027 hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready 0; then out_ready=1 -> IDLE next edge.
REQ-028 assert rst at idx=2 of an add -> all outputs 0 immediately, no out_valid; next command completes correctly.
